// File: rtl/muldiv_hilo.sv
// muldiv_hilo: HI/LO owner and ABP sequencer for the multiplier and divider engines.
// Engine ops toggle a request level and wait for the matching ack level; MT*/MF* finish in one cycle.
module muldiv_hilo #(
   parameter bit ZERO_DIV_BYPASS = 1'b1
) (
   input  logic        sys_clock_i,
   input  logic        sys_reset_i,
   input  logic        op_valid_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   output logic        op_ready_o,
   output logic        busy_o,
   output logic [31:0] rd_data_o,
   output logic        rd_valid_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [31:0] opa_o,
   output logic [31:0] opb_o,
   output logic        signed_o,
   output logic        mul_req_o,
   input  logic        mul_ack_i,
   input  logic [63:0] mul_product_i,
   output logic        div_req_o,
   input  logic        div_ack_i,
   input  logic [31:0] div_quotient_i,
   input  logic [31:0] div_remainder_i
);
   typedef enum logic [1:0] {IDLE, MUL_WAIT, DIV_WAIT} state_t;
   localparam logic [2:0] OP_MTHI = 3'd4, OP_MTLO = 3'd5, OP_MFHI = 3'd6, OP_MFLO = 3'd7;
   state_t      state_q, state_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d, rd_data_q, rd_data_d, opa_q, opa_d, opb_q, opb_d;
   logic        rd_valid_q, rd_valid_d, signed_q, signed_d, mul_req_q, mul_req_d, div_req_q, div_req_d;
   always_comb begin
      state_d    = state_q;
      hi_d       = hi_q;
      lo_d       = lo_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      opa_d      = opa_q;
      opb_d      = opb_q;
      signed_d   = signed_q;
      mul_req_d  = mul_req_q;
      div_req_d  = div_req_q;
      case (state_q)
         IDLE: if (op_valid_i) begin
            if (op_i == OP_MTHI) hi_d = rs_i;
            else if (op_i == OP_MTLO) lo_d = rs_i;
            else if (op_i == OP_MFHI || op_i == OP_MFLO) begin
               rd_data_d  = (op_i == OP_MFHI) ? hi_q : lo_q;
               rd_valid_d = 1'b1;
            end else if (op_i[1] && ZERO_DIV_BYPASS && rt_i == '0) begin
               hi_d = rs_i;
               lo_d = '1;
            end else begin
               // op_i[2] is 0 here: bit 1 picks the engine, bit 0 clear means signed
               opa_d    = rs_i;
               opb_d    = rt_i;
               signed_d = !op_i[0];
               if (op_i[1]) begin
                  div_req_d = !div_req_q;
                  state_d   = DIV_WAIT;
               end else begin
                  mul_req_d = !mul_req_q;
                  state_d   = MUL_WAIT;
               end
            end
         end
         MUL_WAIT: if (mul_ack_i == mul_req_q) begin
            hi_d    = mul_product_i[63:32];
            lo_d    = mul_product_i[31:0];
            state_d = IDLE;
         end
         DIV_WAIT: if (div_ack_i == div_req_q) begin
            lo_d    = div_quotient_i;
            hi_d    = div_remainder_i;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge sys_clock_i or posedge sys_reset_i) begin
      if (sys_reset_i) begin
         state_q    <= IDLE;
         hi_q       <= '0;
         lo_q       <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         opa_q      <= '0;
         opb_q      <= '0;
         signed_q   <= 1'b0;
         mul_req_q  <= 1'b0;
         div_req_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         opa_q      <= opa_d;
         opb_q      <= opb_d;
         signed_q   <= signed_d;
         mul_req_q  <= mul_req_d;
         div_req_q  <= div_req_d;
      end
   end
   assign op_ready_o = (state_q == IDLE);
   assign busy_o     = (state_q != IDLE);
   assign rd_data_o  = rd_data_q;
   assign rd_valid_o = rd_valid_q;
   assign hi_o       = hi_q;
   assign lo_o       = lo_q;
   assign opa_o      = opa_q;
   assign opb_o      = opb_q;
   assign signed_o   = signed_q;
   assign mul_req_o  = mul_req_q;
   assign div_req_o  = div_req_q;
endmodule

// File: tb/tb_muldiv_hilo.sv
// tb_muldiv_hilo: directed plus random ops against an arithmetic HI/LO model.
// The engines are modelled as ABP responders that ack 34 edges after the request toggle.
module tb_muldiv_hilo;
   logic        clk, rst, op_valid_i, op_ready_o, busy_o, rd_valid_o, signed_o;
   logic [2:0]  op_i;
   logic [31:0] rs_i, rt_i, rd_data_o, hi_o, lo_o, opa_o, opb_o;
   logic        mul_req_o, mul_ack, div_req_o, div_ack;
   logic [63:0] mul_p;
   logic [31:0] div_q, div_r;
   logic        mul_run, div_run;
   int          mul_cnt, div_cnt;
   int          checks, errors;
   logic [31:0] exp_hi, exp_lo;

   muldiv_hilo dut (
      .sys_clock_i(clk), .sys_reset_i(rst), .op_valid_i(op_valid_i), .op_i(op_i),
      .rs_i(rs_i), .rt_i(rt_i), .op_ready_o(op_ready_o), .busy_o(busy_o),
      .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .hi_o(hi_o), .lo_o(lo_o),
      .opa_o(opa_o), .opb_o(opb_o), .signed_o(signed_o),
      .mul_req_o(mul_req_o), .mul_ack_i(mul_ack), .mul_product_i(mul_p),
      .div_req_o(div_req_o), .div_ack_i(div_ack),
      .div_quotient_i(div_q), .div_remainder_i(div_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [63:0] ref_mul(input logic [31:0] a, b, input logic s);
      logic [63:0] ea, eb;
      ea = s ? {{32{a[31]}}, a} : {32'b0, a};
      eb = s ? {{32{b[31]}}, b} : {32'b0, b};
      return ea * eb;
   endfunction

   function automatic logic [63:0] ref_div(input logic [31:0] a, b, input logic s);
      logic signed [31:0] sa, sb, q, r;
      sa = a;
      sb = b;
      if (!s) return {a % b, a / b};
      q = sa / sb;
      r = sa % sb;
      return {r, q};
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         mul_ack <= 1'b0; mul_run <= 1'b0; mul_cnt <= 0; mul_p <= '0;
      end else if (!mul_run) begin
         if (mul_req_o != mul_ack) begin
            mul_run <= 1'b1; mul_cnt <= 0; mul_p <= ref_mul(opa_o, opb_o, signed_o);
         end
      end else if (mul_cnt == 32) begin
         mul_ack <= ~mul_ack; mul_run <= 1'b0;
      end else mul_cnt <= mul_cnt + 1;
   end

   always @(posedge clk) begin
      if (rst) begin
         div_ack <= 1'b0; div_run <= 1'b0; div_cnt <= 0; div_q <= '0; div_r <= '0;
      end else if (!div_run) begin
         if (div_req_o != div_ack) begin
            div_run <= 1'b1; div_cnt <= 0;
            {div_r, div_q} <= ref_div(opa_o, opb_o, signed_o);
         end
      end else if (div_cnt == 32) begin
         div_ack <= ~div_ack; div_run <= 1'b0;
      end else div_cnt <= div_cnt + 1;
   end

   task automatic chk(input string tag, input logic [63:0] obs, exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, b, output int w);
      op_i = op; rs_i = a; rt_i = b; op_valid_i = 1'b1; w = 0;
      while (!op_ready_o && w < 200) begin
         @(negedge clk);
         w++;
      end
      @(negedge clk);
      op_valid_i = 1'b0;
   endtask

   task automatic wait_done(input logic [31:0] a, b, input logic s, output int n, output logic ok);
      n = 0; ok = 1'b1;
      do begin
         if (busy_o && (opa_o !== a || opb_o !== b || signed_o !== s)) ok = 1'b0;
         @(negedge clk);
         n++;
      end while (!op_ready_o && n < 200);
   endtask

   task automatic eng(input logic [2:0] op, input logic [31:0] a, b);
      logic pm, pd, s, ok;
      logic [63:0] r;
      int w, n;
      pm = mul_req_o; pd = div_req_o; s = !op[0];
      issue(op, a, b, w);
      chk("accept_wait", w, 0);
      if (op[1] && b == 0) begin
         chk("bypass_div_req", div_req_o, pd);
         chk("bypass_ready", op_ready_o, 1);
         exp_hi = a; exp_lo = 32'hFFFFFFFF;
      end else begin
         chk("req_toggle", op[1] ? {div_req_o, mul_req_o} : {mul_req_o, div_req_o},
             op[1] ? {~pd, pm} : {~pm, pd});
         chk("busy_after_issue", {busy_o, op_ready_o}, 2'b10);
         wait_done(a, b, s, n, ok);
         chk("latency", n, 35);
         chk("operands_held", ok, 1);
         if (op[1]) begin
            r = ref_div(a, b, s); exp_lo = r[31:0]; exp_hi = r[63:32];
         end else begin
            r = ref_mul(a, b, s); exp_hi = r[63:32]; exp_lo = r[31:0];
         end
      end
      chk("hi", hi_o, exp_hi);
      chk("lo", lo_o, exp_lo);
   endtask

   initial begin
      int w;
      logic [2:0] op;
      logic [31:0] a, b;
      checks = 0; errors = 0; exp_hi = 0; exp_lo = 0;
      rst = 1'b1; op_valid_i = 1'b0; op_i = '0; rs_i = '0; rt_i = '0;
      @(negedge clk);
      chk("rst_ctrl", {op_ready_o, busy_o, mul_req_o, div_req_o, rd_valid_o, signed_o}, 6'b100000);
      chk("rst_hilo", {hi_o, lo_o}, 0);
      chk("rst_ops", {opa_o, opb_o}, 0);
      chk("rst_rd", rd_data_o, 0);
      rst = 1'b0;
      @(negedge clk);

      eng(3'd1, 32'd17, 32'd3);
      eng(3'd0, -32'sd7, 32'd3);
      chk("mult_neg_hi", hi_o, 32'hFFFFFFFF);

      issue(3'd3, 32'd17, 32'd5, w);
      issue(3'd7, 32'd0, 32'd0, w);
      chk("mflo_stall", w, 35);
      chk("mflo_pulse", {rd_valid_o, rd_data_o}, {1'b1, 32'd3});
      chk("divu_hilo", {hi_o, lo_o}, {32'd2, 32'd3});
      @(negedge clk);
      chk("mflo_single", rd_valid_o, 0);
      exp_hi = 2; exp_lo = 3;

      eng(3'd2, 32'd9, 32'd0);
      issue(3'd4, 32'h1234, 32'd0, w);
      chk("mthi", hi_o, 32'h1234);
      exp_hi = 32'h1234;
      issue(3'd6, 32'd0, 32'd0, w);
      chk("mfhi_b2b_wait", w, 0);
      chk("mfhi_b2b", {rd_valid_o, rd_data_o}, {1'b1, 32'h1234});

      for (int i = 0; i < 25; i++) begin
         op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
         if (op[2:1] == 2'b01 && $urandom_range(0, 3) == 0) b = 0;
         if (op == 3'd2 && a == 32'h80000000 && b == 32'hFFFFFFFF) b = 1;
         if (!op[2]) eng(op, a, b);
         else begin
            issue(op, a, b, w);
            chk("rnd_wait", w, 0);
            if (op == 3'd4) exp_hi = a;
            if (op == 3'd5) exp_lo = a;
            if (op[1]) chk("rnd_mf", {rd_valid_o, rd_data_o}, {1'b1, op[0] ? exp_lo : exp_hi});
            else chk("rnd_mt", {hi_o, lo_o}, {exp_hi, exp_lo});
         end
      end

      issue(3'd0, $urandom, $urandom, w);
      repeat (10) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_ctrl", {op_ready_o, busy_o, mul_req_o, div_req_o}, 4'b1000);
      chk("arst_hilo", {hi_o, lo_o}, 0);
      @(negedge clk);
      rst = 1'b0;
      exp_hi = 0; exp_lo = 0;
      repeat (30) @(negedge clk);
      chk("post_rst_hilo", {hi_o, lo_o}, 0);
      eng(3'd1, 32'd2, 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Sequencing front-end for the M1 integer multiplier and divider. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO operations from the execute stage and drives the two engines over their Alternating Bit Protocol (ABP) interfaces. Owns the architectural HI/LO registers and stalls the issuing stage while an engine is running.

## Interface
- ZERO_DIV_BYPASS, default 1: when 1, DIV/DIVU with rt_i==0 completes locally and issues no divider request.
- sys_clock_i  in  1  system clock, rising edge.
- sys_reset_i  in  1  reset; asynchronous and active-high.
- op_valid_i  in  1  operation offered this cycle.
- op_i  in  3  operation code:
  - 0 MULT, 1 MULTU, 2 DIV, 3 DIVU.
  - 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
- rs_i, rt_i  in  32 each  source operands; rs is the dividend or multiplicand.
- op_ready_o  out  1  operation accepted at this edge if op_valid_i; combinational, equals (state==IDLE).
- busy_o  out  1  engine operation in flight; equals (state!=IDLE).
- rd_data_o  out  32  MFHI/MFLO result, registered.
- rd_valid_o  out  1  one-cycle pulse, qualifies rd_data_o.
- hi_o, lo_o  out  32 each  current HI/LO register values.
- opa_o, opb_o  out  32 each  latched operands, shared by both engines.
- signed_o  out  1  latched signedness, shared by both engines.
- mul_req_o  out  1  multiplier ABP request level.
- mul_ack_i  in  1  multiplier ABP ack level.
- mul_product_i  in  64  multiplier product.
- div_req_o  out  1  divider ABP request level.
- div_ack_i  in  1  divider ABP ack level.
- div_quotient_i, div_remainder_i  in  32 each  divider results.

## Operation
- States: IDLE, MUL_WAIT, DIV_WAIT.
- Acceptance: op_valid_i && op_ready_o at a rising edge. While busy, nothing is accepted; the issuer holds op_valid_i/op_i/rs_i/rt_i until accepted.
- IDLE, MTHI/MTLO: HI (or LO) <= rs_i; stay IDLE.
- IDLE, MFHI/MFLO: rd_data_o <= HI (or LO); rd_valid_o <= 1 for one cycle; stay IDLE.
- IDLE, MULT/MULTU:
  - opa_o <= rs_i, opb_o <= rt_i, signed_o <= (op_i==MULT).
  - mul_req_o <= ~mul_req_o; go to MUL_WAIT.
- IDLE, DIV/DIVU with ZERO_DIV_BYPASS && rt_i==0: HI <= rs_i, LO <= 32'hFFFFFFFF; stay IDLE; div_req_o unchanged.
- IDLE, DIV/DIVU otherwise: latch operands as for multiply, with signed_o <= (op_i==DIV); div_req_o <= ~div_req_o; go to DIV_WAIT.
- MUL_WAIT: when mul_ack_i == mul_req_o, HI <= mul_product_i[63:32], LO <= mul_product_i[31:0]; go to IDLE.
- DIV_WAIT: when div_ack_i == div_req_o, LO <= div_quotient_i, HI <= div_remainder_i; go to IDLE.
- opa_o, opb_o and signed_o are held constant from the toggle until completion. Both engines sample them one edge after the toggle.
- Ack from the engine that is not being waited on is ignored. Only one engine is ever in flight.
- Engine results are passed through unmodified; no sign correction in this block.

## Timing
- Reset values: state IDLE; all of the following are 0:
  - mul_req_o, div_req_o, rd_valid_o, rd_data_o.
  - hi_o, lo_o, opa_o, opb_o, signed_o.
- Reset mid-operation: abandons the operation immediately, with no HI/LO update. The engines share the same reset (synchronous on their side); sys_reset_i must span at least one rising edge so their ack and last-request levels also return to 0.
- MT*/MF*/zero-divide bypass: 1 cycle; op_ready_o stays high, so back-to-back issue is allowed.
- MFHI issued the cycle after MTHI returns the new value (write lands at the same edge that accepts the MFHI read? No: MTHI writes at edge N, MFHI reads at edge N+1 and sees the updated HI).
- MULT/DIV accepted at edge N:
  - req toggles at N.
  - Engine latches at N+1, computes through N+33, raises ack at N+34.
  - HI/LO update and return to IDLE at N+35.
  - op_ready_o is low from after N to after N+35.
- Ack equality is never true in the first WAIT cycle, because ack still holds the previous level.
- MFHI/MFLO offered during MUL_WAIT/DIV_WAIT stalls. It is accepted at the completion edge's following cycle and returns the new value.

## Test plan
- Reset asserted mid-cycle, asynchronously -> immediately op_ready_o=1, busy_o=0, hi_o=lo_o=0, both req outputs 0.
- MULTU rs=17, rt=3 -> mul_req_o toggles once; 35 cycles later lo_o=51, hi_o=0, op_ready_o=1.
- MULT rs=-7, rt=3 -> lo_o=32'hFFFFFFEB, hi_o=32'hFFFFFFFF; signed_o=1 throughout MUL_WAIT.
- DIVU rs=17, rt=5, then MFLO held valid -> MFLO stalls until completion; lo_o=3, hi_o=2; rd_data_o=3 with a single rd_valid_o pulse.
- DIV rs=9, rt=0; then MTHI rs=0x1234 and MFHI back-to-back:
  - div_req_o unchanged; hi_o=9, lo_o=32'hFFFFFFFF after 1 cycle.
  - hi_o=0x1234, and MFHI returns 0x1234 the following cycle.
- MULT accepted, reset pulsed at cycle 10, then MULTU 2*2 -> HI/LO stay 0 through the reset; the new op completes with lo_o=4 after 35 cycles.
